// File: rtl/pwm_multichannel_generator.sv
// pwm_multichannel_generator: NUM_CH edge-aligned PWM channels sharing one prescaled period counter
module pwm_multichannel_generator #(
    parameter int NUM_CH  = 2,
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [PRESC_W-1:0]      prescale,
    input  logic [WIDTH-1:0]        period,
    input  logic [NUM_CH*WIDTH-1:0] duty_in,
    input  logic                    duty_load,
    output logic                    load_pending,
    output logic                    period_tick,
    output logic [NUM_CH-1:0]       pwm_out
);
    logic [PRESC_W-1:0]      pre_cnt;
    logic [WIDTH-1:0]        cnt;
    logic [WIDTH-1:0]        period_act;
    logic [WIDTH-1:0]        period_stg;
    logic [NUM_CH*WIDTH-1:0] duty_act;
    logic [NUM_CH*WIDTH-1:0] duty_stg;
    logic                    tick;
    logic                    wrap;
    logic                    apply;
    logic [NUM_CH-1:0]       cmp;

    // counter advance, wrap detection and when staged values get promoted (wrap or while disabled)
    always_comb begin
        tick  = enable && (pre_cnt == prescale);
        wrap  = tick && (cnt >= period_act);
        apply = load_pending && (wrap || !enable);
    end

    // unsigned per-channel compare against the shared counter
    always_comb begin
        cmp = '0;
        for (int i = 0; i < NUM_CH; i++)
            cmp[i] = enable && (cnt < duty_act[i*WIDTH +: WIDTH]);
    end

    // prescaler and period counter; wrap is by compare so cnt never exceeds period_act
    always_ff @(posedge clk) begin
        if (!reset || !enable) begin
            pre_cnt     <= '0;
            cnt         <= '0;
            period_tick <= 1'b0;
        end else begin
            pre_cnt     <= tick ? '0 : pre_cnt + 1'b1;
            period_tick <= wrap;
            if (tick)
                cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

    // staging capture and boundary apply; a load coincident with apply keeps the new values pending
    always_ff @(posedge clk) begin
        if (!reset) begin
            duty_act     <= '0;
            period_act   <= '1;
            duty_stg     <= '0;
            period_stg   <= '0;
            load_pending <= 1'b0;
        end else begin
            if (apply) begin
                duty_act   <= duty_stg;
                period_act <= period_stg;
            end
            if (duty_load) begin
                duty_stg   <= duty_in;
                period_stg <= period;
            end
            load_pending <= duty_load || (load_pending && !apply);
        end
    end

    // registered outputs, one clock behind the counter
    always_ff @(posedge clk) begin
        pwm_out <= reset ? cmp : '0;
    end
endmodule

// File: tb/tb_pwm_multichannel_generator.sv
// tb_pwm_multichannel_generator: directed and random checks against a behavioural PWM model
module tb_pwm_multichannel_generator;
    localparam int NUM_CH  = 2;
    localparam int WIDTH   = 8;
    localparam int PRESC_W = 8;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    enable = 1'b0;
    logic [PRESC_W-1:0]      prescale = '0;
    logic [WIDTH-1:0]        period = '0;
    logic [NUM_CH*WIDTH-1:0] duty_in = '0;
    logic                    duty_load = 1'b0;
    logic                    load_pending;
    logic                    period_tick;
    logic [NUM_CH-1:0]       pwm_out;

    pwm_multichannel_generator #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .prescale(prescale), .period(period),
        .duty_in(duty_in), .duty_load(duty_load), .load_pending(load_pending),
        .period_tick(period_tick), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    int m_pre, m_cnt, m_per, s_per;
    int m_duty[NUM_CH];
    int s_duty[NUM_CH];
    bit m_pend, m_tick;
    logic [NUM_CH-1:0] m_pwm;

    int cyc = 0, last_tick = 0, gap = 0;
    int hi[NUM_CH];
    int last_hi[NUM_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick_clk();
        bit apply;
        @(posedge clk);
        apply = 0;
        if (!reset) begin
            m_pre = 0; m_cnt = 0; m_per = (1 << WIDTH) - 1; s_per = 0;
            m_pend = 0; m_tick = 0; m_pwm = '0;
            for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = 0; s_duty[i] = 0; end
        end else begin
            for (int i = 0; i < NUM_CH; i++) m_pwm[i] = enable && (m_cnt < m_duty[i]);
            m_tick = 0;
            if (!enable) begin
                m_pre = 0; m_cnt = 0; apply = m_pend;
            end else if (m_pre == int'(prescale)) begin
                m_pre = 0;
                if (m_cnt >= m_per) begin m_cnt = 0; m_tick = 1; apply = m_pend; end
                else m_cnt++;
            end else m_pre = (m_pre + 1) % (1 << PRESC_W);
            if (apply) begin m_duty = s_duty; m_per = s_per; m_pend = 0; end
            if (duty_load) begin
                for (int i = 0; i < NUM_CH; i++) s_duty[i] = int'(duty_in[i*WIDTH +: WIDTH]);
                s_per = int'(period); m_pend = 1;
            end
        end
        #1;
        cyc++;
        check("pwm_out", pwm_out, m_pwm);
        check("period_tick", period_tick, m_tick);
        check("load_pending", load_pending, m_pend);
        if (m_tick) begin
            gap = cyc - last_tick; last_tick = cyc;
            last_hi = hi;
            for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
        end
        for (int i = 0; i < NUM_CH; i++) hi[i] += int'(pwm_out[i]);
    endtask

    task automatic run_ticks(input int n);
        int seen = 0;
        for (int c = 0; c < 5000 && seen < n; c++) begin
            tick_clk();
            if (m_tick) seen++;
        end
        check("tick_timeout", seen, n);
    endtask

    task automatic wait_cnt(input int v);
        for (int c = 0; c < 5000 && m_cnt != v; c++) tick_clk();
        if (m_cnt != v) check("cnt_timeout", 0, 1);
    endtask

    task automatic load(input int d0, input int d1, input int p);
        duty_in[0 +: WIDTH] = WIDTH'(d0);
        duty_in[WIDTH +: WIDTH] = WIDTH'(d1);
        period = WIDTH'(p);
        duty_load = 1'b1;
        tick_clk();
        duty_load = 1'b0;
    endtask

    task automatic ticks_to_wrap(input int exp, input string tag);
        int n = 0;
        for (int c = 0; c < 5000; c++) begin
            tick_clk(); n++;
            if (m_tick) break;
        end
        check(tag, n, exp);
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin hi[i] = 0; last_hi[i] = 0; end
        // T1 reset held with enable and duty_load active
        enable = 1'b1; duty_load = 1'b1; duty_in = '1; period = 8'd5;
        for (int k = 0; k < 3; k++) begin
            tick_clk();
            check("rst_pwm", pwm_out, 0);
            check("rst_pend", load_pending, 0);
        end
        duty_load = 1'b0; reset = 1'b1;
        run_ticks(2);
        check("t1_gap", gap, 256);
        // T2 duty 64/192 at full period
        load(64, 192, 255);
        check("t2_pend", load_pending, 1);
        run_ticks(2);
        check("t2_hi0", last_hi[0], 64);
        check("t2_hi1", last_hi[1], 192);
        // T3 limits with short period and prescale 1
        prescale = 8'd1;
        load(10, 0, 9);
        run_ticks(3);
        check("t3_gap", gap, 20);
        check("t3_full", last_hi[0], 20);
        check("t3_zero", last_hi[1], 0);
        load(5, 10, 9);
        run_ticks(3);
        check("t3_half", last_hi[0], 10);
        check("t3_full2", last_hi[1], 20);
        // T4 mid-period double load; last wins at the boundary
        prescale = 8'd0;
        load(150, 150, 255);
        run_ticks(3);
        wait_cnt(100);
        load(32, 32, 255);
        tick_clk();
        load(200, 200, 255);
        run_ticks(1);
        check("t4_old", last_hi[0], 150);
        run_ticks(1);
        check("t4_new", last_hi[0], 200);
        // T5 load coincident with the wrap, nothing pending
        wait_cnt(255);
        load(20, 40, 255);
        check("t5_pend", load_pending, 1);
        run_ticks(1);
        check("t5_notapplied", last_hi[0], 200);
        run_ticks(1);
        check("t5_applied", last_hi[0], 20);
        check("t5_applied1", last_hi[1], 40);
        // T6 enable drop applies pending, re-enable gives a full period
        load(30, 60, 99);
        wait_cnt(50);
        enable = 1'b0;
        tick_clk();
        check("t6_pwm", pwm_out, 0);
        check("t6_pend", load_pending, 0);
        repeat (3) tick_clk();
        enable = 1'b1;
        ticks_to_wrap(100, "t6_reen_gap");
        run_ticks(1);
        check("t6_hi0", last_hi[0], 30);
        check("t6_hi1", last_hi[1], 60);
        // T6 reset mid-run restores reset values
        load(70, 80, 99);
        wait_cnt(50);
        reset = 1'b0;
        tick_clk();
        check("t6r_pwm", pwm_out, 0);
        check("t6r_tick", period_tick, 0);
        check("t6r_pend", load_pending, 0);
        reset = 1'b1;
        ticks_to_wrap(256, "t6r_gap");
        run_ticks(1);
        check("t6r_hi0", last_hi[0], 0);
        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            duty_load = ($urandom_range(0, 15) == 0);
            if (duty_load) begin
                period = WIDTH'($urandom_range(3, 40));
                for (int i = 0; i < NUM_CH; i++) duty_in[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 45));
            end
            if ($urandom_range(0, 99) == 0) prescale = PRESC_W'($urandom_range(0, 3));
            enable = ($urandom_range(0, 63) != 0);
            reset = ($urandom_range(0, 299) != 0);
            tick_clk();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
